datapath_mc: RTL
================

# datapath_mc

Parametrised multi-cycle datapath: a general-purpose register file plus PC, IR, RY, RZ, MAR, HI, LO and MDR on a single shared bus. It succeeds the single-cycle datapath with several additions: configurable register count, encoded ALU opcodes, iterative signed MUL/DIV behind a start/busy/done handshake, a memory-read handshake into MDR, bus-conflict detection, and an optional hardwired-zero R0. The block sits between the control unit, which drives the select strobes, and memory.

## Interface
- BITS, 32, datapath width; ≥8, power of two
- REGISTERS, 16, general-purpose register count; ≥2
- R0_ZERO, 0, 1 = R0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  reset; synchronous, active-high
- reg_in  in  REGISTERS  one-hot-or-zero bus load strobes for R0..R(n-1)
- reg_out  in  REGISTERS  bus drive selects for R0..R(n-1)
- spec_in  in  7  load strobes, bit order {MDRin, LOin, HIin, MARin, RYin, IRin, PCin}
- spec_out  in  6  drive selects, bit order {MDRout, LOout, HIout, RZHIout, RZLOout, PCout}
- alu_op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 AND, 9 OR, 10 NEG, 11 NOT; 12-15 are reserved
- alu_start  in  1  pulse; samples alu_op, RY and bus
- mem_rd_req  in  1  pulse; starts a memory read at address MAR
- mem_ready  in  1  memory has valid data on mem_data_in
- mem_data_in  in  BITS  memory read data
- bus  out  BITS  current bus value
- gen_regs  out  BITS*REGISTERS  R(n-1)..R0 concatenated, R0 in the LSBs
- ir_val  out  BITS  IR contents
- mem_addr  out  BITS  MAR contents
- mem_rd  out  1  read request, held until accepted
- alu_busy  out  1  multi-cycle operation in progress
- alu_done  out  1  one-cycle pulse; RZ holds the new result
- div_zero  out  1  last DIV had a zero divisor
- bus_err  out  1  more than one bus driver selected

## Operation
- **Bus**
  - The bus carries the single selected source from {reg_out, spec_out}.
  - The bus is 0 when no source is selected.
  - If two or more selects are active, the bus is 0 and bus_err=1; bus_err is combinational.
- **Register loads**
  - Every register whose in-strobe is high loads the bus at the edge.
  - Multiple simultaneous loads are legal.
  - With R0_ZERO=1, R0 reads 0 and writes to it are dropped.
- **ALU**
  - Operands are A=RY and B=bus, captured at the start edge.
  - RZ is 2*BITS wide.
  - Single-cycle ops write RZ={0, result}:
    - ADD/SUB: wrap modulo 2^BITS, no flags.
    - SHR: logical shift of A right by B[log2(BITS)-1:0].
    - SHL: shift of A left by the same amount.
    - ROR/ROL: rotate A by the same amount.
    - AND/OR: bitwise.
    - NEG: −B in two's complement.
    - NOT: ~B.
  - Reserved opcodes write RZ=0 with single-cycle latency.
  - MUL: signed, shift-add, one bit per cycle; RZ={product[2B-1:B], product[B-1:0]}.
  - DIV: signed restoring division, one bit per cycle.
    - RZ={remainder, quotient}; quotient truncates toward zero; remainder takes the sign of the dividend.
    - A is the dividend and B the divisor.
    - B=0 gives quotient all-ones, remainder=A and div_zero=1.
  - div_zero is updated on every alu_done: set by a zero-divisor DIV, cleared by any other completion.
- **ALU FSM**: IDLE → (start & MUL/DIV) → ITER (count BITS-1..0) → FINISH → IDLE.
  - Single-cycle ops stay in IDLE.
- **Memory FSM**: IDLE → (mem_rd_req) → WAIT.
  - WAIT asserts mem_rd.
  - On mem_ready, MDR loads mem_data_in and the FSM returns to IDLE.
  - A mem_rd_req while in WAIT is ignored.
  - If mem_ready and MDRin occur in the same cycle, the memory data wins.

## Timing
- **Reset** (clr high at an edge):
  - All registers, RZ and FSMs are cleared to 0/IDLE.
  - mem_rd, alu_busy, alu_done and div_zero are 0.
  - An operation in flight is aborted: RZ is not written and no done pulse is issued.
- **Single-cycle op**: start at edge E; RZ is written at edge E; alu_done is high the cycle after E.
  - alu_busy never asserts.
- **MUL/DIV**: start at edge E; alu_busy is high from E+1 through E+BITS; RZ is written at edge E+BITS; alu_done is high in the cycle after E+BITS.
  - Latency is BITS cycles.
- **Start while busy** is ignored.
- **Start during the alu_done cycle** is accepted as a new operation.
- RZ is not affected by RZin-style bus loads; only the ALU writes RZ.
- **Memory read**: mem_rd_req at edge E makes mem_rd high from E+1.
  - mem_ready sampled high at edge F loads MDR at F, and mem_rd drops after F.
  - The minimum read is 1 wait cycle.
- mem_addr reflects a MAR load in the cycle after the load edge.

## Test plan
- **Basic ADD:** R3=5 via bus, R4=7; R3out+RYin, then R4out+ADD start → alu_done after 1 cycle, RZLOout bus=12, RZHIout=0, busy never high.
- **MUL:** RY=−3, bus=6, MUL → busy exactly BITS cycles, RZ={FFFFFFFF, FFFFFFEE}; a start issued mid-busy is ignored.
- **DIV:** RY=−7, bus=2 → RZ={FFFFFFFF, FFFFFFFD}, div_zero=0; then bus=0 → quotient FFFFFFFF, remainder FFFFFFF9, div_zero=1.
- **Bus conflict:** R1out and PCout asserted together → bus=0, bus_err=1; R2in that cycle loads 0. With R0_ZERO=1, a write of 0xA5 to R0 still reads 0.
- **Memory read:** MAR=0x80, mem_rd_req, mem_ready delayed 3 cycles with data 0xDEADBEEF → mem_rd high 3 cycles, MDR=0xDEADBEEF; a simultaneous MDRin is overridden.
- **Reset mid-op:** clr asserted at iteration 10 of a DIV → alu_busy=0 next cycle, no alu_done, RZ=0, all outputs 0.

Source files
------------

// File: rtl/datapath_mc.sv
// datapath_mc: shared-bus datapath with a register file, iterative signed MUL/DIV and an MDR read handshake.
module datapath_mc #(
    parameter int BITS = 32,
    parameter int REGISTERS = 16,
    parameter int R0_ZERO = 0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [REGISTERS-1:0]      reg_in,
    input  logic [REGISTERS-1:0]      reg_out,
    input  logic [6:0]                spec_in,
    input  logic [5:0]                spec_out,
    input  logic [3:0]                alu_op,
    input  logic                      alu_start,
    input  logic                      mem_rd_req,
    input  logic                      mem_ready,
    input  logic [BITS-1:0]           mem_data_in,
    output logic [BITS-1:0]           bus,
    output logic [BITS*REGISTERS-1:0] gen_regs,
    output logic [BITS-1:0]           ir_val,
    output logic [BITS-1:0]           mem_addr,
    output logic                      mem_rd,
    output logic                      alu_busy,
    output logic                      alu_done,
    output logic                      div_zero,
    output logic                      bus_err
);
    localparam int SW = $clog2(BITS);
    typedef enum logic [1:0] {A_IDLE, A_ITER, A_FIN} alu_st_t;
    typedef enum logic {M_IDLE, M_WAIT} mem_st_t;
    alu_st_t st_q, st_d;
    mem_st_t mst_q, mst_d;
    logic [BITS-1:0] r_q [REGISTERS];
    logic [BITS-1:0] rv [REGISTERS];
    logic [BITS-1:0] pc_q, ir_q, ry_q, mar_q, hi_q, lo_q, mdr_q, m_q, a_q;
    logic [BITS-1:0] bus_or, res, ror_v, rol_v, ma, mb, q_m, r_m;
    logic [2*BITS-1:0] rz_q, p_q, step, fin;
    logic [BITS:0] sum, diff;
    logic [SW-1:0] sh, cnt_q;
    logic mul_q, neg_q, sa_q, dz_q, div_zero_q, done_q, is_md;
    for (genvar i = 0; i < REGISTERS; i++) begin : g_rd
        assign rv[i] = (R0_ZERO != 0 && i == 0) ? '0 : r_q[i];
        assign gen_regs[i*BITS +: BITS] = rv[i];
    end
    always_comb begin
        bus_or = (spec_out[0] ? pc_q : '0) | (spec_out[1] ? rz_q[BITS-1:0] : '0)
               | (spec_out[2] ? rz_q[2*BITS-1:BITS] : '0) | (spec_out[3] ? hi_q : '0)
               | (spec_out[4] ? lo_q : '0) | (spec_out[5] ? mdr_q : '0);
        for (int k = 0; k < REGISTERS; k++) bus_or = bus_or | (reg_out[k] ? rv[k] : '0);
    end
    assign bus_err  = $countones({reg_out, spec_out}) > 1;
    assign bus      = bus_err ? '0 : bus_or;
    assign ir_val   = ir_q;
    assign mem_addr = mar_q;
    assign mem_rd   = mst_q == M_WAIT;
    assign alu_busy = st_q == A_ITER;
    assign alu_done = done_q;
    assign div_zero = div_zero_q;
    // single-cycle ALU results; shift/rotate amount is the low log2(BITS) bits of the bus
    assign sh    = bus[SW-1:0];
    assign ror_v = BITS'({ry_q, ry_q} >> sh);
    assign rol_v = BITS'(({ry_q, ry_q} << sh) >> BITS);
    always_comb begin
        res = '0;
        case (alu_op)
            4'd0:    res = ry_q + bus;
            4'd1:    res = ry_q - bus;
            4'd4:    res = ry_q >> sh;
            4'd5:    res = ry_q << sh;
            4'd6:    res = ror_v;
            4'd7:    res = rol_v;
            4'd8:    res = ry_q & bus;
            4'd9:    res = ry_q | bus;
            4'd10:   res = -bus;
            4'd11:   res = ~bus;
            default: res = '0;
        endcase
    end
    // MUL/DIV iterate on magnitudes; signs are applied when RZ is written
    assign is_md = alu_op == 4'd2 || alu_op == 4'd3;
    assign ma    = ry_q[BITS-1] ? -ry_q : ry_q;
    assign mb    = bus[BITS-1] ? -bus : bus;
    assign sum   = {1'b0, p_q[2*BITS-1:BITS]} + {1'b0, p_q[0] ? m_q : '0};
    assign diff  = {p_q[2*BITS-1], p_q[2*BITS-2:BITS-1]} - {1'b0, m_q};
    assign step  = mul_q ? {sum, p_q[BITS-1:1]}
                 : diff[BITS] ? {p_q[2*BITS-2:0], 1'b0} : {diff[BITS-1:0], p_q[BITS-2:0], 1'b1};
    assign q_m   = step[BITS-1:0];
    assign r_m   = step[2*BITS-1:BITS];
    assign fin   = mul_q ? (neg_q ? -step : step)
                 : dz_q ? {a_q, {BITS{1'b1}}} : {sa_q ? -r_m : r_m, neg_q ? -q_m : q_m};
    always_comb begin
        st_d = A_IDLE;
        if (st_q == A_ITER) st_d = cnt_q == '0 ? A_FIN : A_ITER;
        else if (alu_start && is_md) st_d = A_ITER;
    end
    always_comb begin
        mst_d = mst_q;
        if (mst_q == M_IDLE) mst_d = mem_rd_req ? M_WAIT : M_IDLE;
        else if (mem_ready) mst_d = M_IDLE;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            st_q <= A_IDLE;
            mst_q <= M_IDLE;
            rz_q <= '0;
            p_q <= '0;
            m_q <= '0;
            a_q <= '0;
            cnt_q <= '0;
            {mul_q, neg_q, sa_q, dz_q, div_zero_q, done_q} <= '0;
        end else begin
            st_q <= st_d;
            mst_q <= mst_d;
            done_q <= 1'b0;
            if (st_q == A_ITER) begin
                p_q <= step;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    rz_q <= fin;
                    done_q <= 1'b1;
                    div_zero_q <= !mul_q && dz_q;
                end
            end else if (alu_start && is_md) begin
                mul_q <= alu_op == 4'd2;
                p_q <= {{BITS{1'b0}}, alu_op == 4'd2 ? mb : ma};
                m_q <= alu_op == 4'd2 ? ma : mb;
                a_q <= ry_q;
                sa_q <= ry_q[BITS-1];
                neg_q <= ry_q[BITS-1] ^ bus[BITS-1];
                dz_q <= bus == '0;
                cnt_q <= SW'(BITS - 1);
            end else if (alu_start) begin
                rz_q <= {{BITS{1'b0}}, res};
                done_q <= 1'b1;
                div_zero_q <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < REGISTERS; k++) r_q[k] <= '0;
            {pc_q, ir_q, ry_q, mar_q, hi_q, lo_q, mdr_q} <= '0;
        end else begin
            for (int k = 0; k < REGISTERS; k++) if (reg_in[k]) r_q[k] <= bus;
            if (spec_in[0]) pc_q <= bus;
            if (spec_in[1]) ir_q <= bus;
            if (spec_in[2]) ry_q <= bus;
            if (spec_in[3]) mar_q <= bus;
            if (spec_in[4]) hi_q <= bus;
            if (spec_in[5]) lo_q <= bus;
            if (mst_q == M_WAIT && mem_ready) mdr_q <= mem_data_in;
            else if (spec_in[6]) mdr_q <= bus;
        end
    end
endmodule
